// File: rtl/button_events_if.sv
// rtl/button_events_if.sv - button level in, event pulses out
interface button_events_if;
    logic in;
    logic held;
    logic press;
    logic release_pulse;
    logic click;
    logic double_click;
    logic long_press;
    logic repeat_pulse;

    // Driver of the button level and consumer of the events.
    modport master (
        output in,
        input  held, press, release_pulse, click, double_click, long_press, repeat_pulse
    );

    // The event generator itself.
    modport slave (
        input  in,
        output held, press, release_pulse, click, double_click, long_press, repeat_pulse
    );
endinterface

// File: rtl/button_events.sv
// rtl/button_events.sv - press/release/click/double/long/repeat pulse generator
module button_events #(
    parameter int LONG_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 300,
    parameter int REPEAT_CYCLES = 200
) (
    input  logic             clk,
    input  logic             resetn,
    button_events_if.slave   bus
);

    localparam int MAX_LG = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int TW = $clog2(MAX_ALL + 1);

    localparam logic [TW-1:0] TIMER_MAX   = '1;
    localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYCLES - 1);
    // Unused when repeat is disabled; the compare is gated by REPEAT_EN.
    localparam logic [TW-1:0] REPEAT_LAST = TW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam bit            REPEAT_EN   = (REPEAT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESSED  = 3'd1,
        WAIT_GAP = 3'd2,
        SECOND   = 3'd3,
        LONG     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          held_q, held_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          click_q, click_d;
    logic          double_click_q, double_click_d;
    logic          long_press_q, long_press_d;
    logic          repeat_q, repeat_d;

    // Next state, saturating timer and the pulses to register at this edge.
    always_comb begin
        state_d        = state_q;
        timer_d        = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
        press_d        = 1'b0;
        release_d      = 1'b0;
        click_d        = 1'b0;
        double_click_d = 1'b0;
        long_press_d   = 1'b0;
        repeat_d       = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (bus.in) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!bus.in) begin
                    state_d   = WAIT_GAP;
                    timer_d   = '0;
                    release_d = 1'b1;
                end else if (timer_q == LONG_LAST) begin
                    state_d      = LONG;
                    timer_d      = '0;
                    long_press_d = 1'b1;
                end
            end
            WAIT_GAP: begin
                // A new press wins over gap expiry in the same cycle.
                if (bus.in) begin
                    state_d = SECOND;
                    timer_d = '0;
                    press_d = 1'b1;
                end else if (timer_q == GAP_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    click_d = 1'b1;
                end
            end
            SECOND: begin
                if (!bus.in) begin
                    state_d        = IDLE;
                    timer_d        = '0;
                    release_d      = 1'b1;
                    double_click_d = 1'b1;
                end else if (timer_q == LONG_LAST) begin
                    state_d      = LONG;
                    timer_d      = '0;
                    long_press_d = 1'b1;
                end
            end
            LONG: begin
                if (!bus.in) begin
                    state_d   = IDLE;
                    timer_d   = '0;
                    release_d = 1'b1;
                end else if (REPEAT_EN && (timer_q == REPEAT_LAST)) begin
                    timer_d  = '0;
                    repeat_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        held_d = (state_d == PRESSED) || (state_d == SECOND) || (state_d == LONG);
    end

    // State, timer and registered outputs; reset drops any pending sequence.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            held_q         <= 1'b0;
            press_q        <= 1'b0;
            release_q      <= 1'b0;
            click_q        <= 1'b0;
            double_click_q <= 1'b0;
            long_press_q   <= 1'b0;
            repeat_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            held_q         <= held_d;
            press_q        <= press_d;
            release_q      <= release_d;
            click_q        <= click_d;
            double_click_q <= double_click_d;
            long_press_q   <= long_press_d;
            repeat_q       <= repeat_d;
        end
    end

    assign bus.held          = held_q;
    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.click         = click_q;
    assign bus.double_click  = double_click_q;
    assign bus.long_press    = long_press_q;
    assign bus.repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - randomized and directed check of button_events against a duration model
module tb_button_events;

    localparam int L = 20;
    localparam int G = 8;
    localparam int R = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    button_events_if bif ();

    button_events #(
        .LONG_CYCLES   (L),
        .GAP_CYCLES    (G),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: which phase of a button gesture we are in, measured in edges.
    int m_phase   = 0;   // 0 no gesture, 1 button down, 2 up and waiting for a second press
    int m_hold    = 0;   // edges since the latest accepted press
    int m_low     = 0;   // edges since the release that started the gap
    int m_presses = 0;
    bit m_long    = 1'b0;
    logic [6:0] exp_vec;

    // Event bookkeeping from observed outputs, for the directed timing checks.
    int t_press, t_rel, t_click, t_dbl, t_long, t_rep1;
    int n_press, n_rel, n_click, n_dbl, n_long, n_rep;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic lvl, input logic rst_n);
        logic e_press, e_rel, e_click, e_dbl, e_long, e_rep;
        e_press = 0; e_rel = 0; e_click = 0; e_dbl = 0; e_long = 0; e_rep = 0;
        if (!rst_n) begin
            m_phase = 0; m_hold = 0; m_low = 0; m_presses = 0; m_long = 0;
        end else begin
            case (m_phase)
                0: if (lvl) begin
                    e_press = 1; m_phase = 1; m_presses = 1; m_hold = 0; m_long = 0;
                end
                1: if (!lvl) begin
                    e_rel = 1;
                    if (m_long) m_phase = 0;
                    else if (m_presses == 2) begin e_dbl = 1; m_phase = 0; end
                    else begin m_phase = 2; m_low = 0; end
                end else begin
                    m_hold++;
                    if (!m_long && m_hold == L) begin e_long = 1; m_long = 1; end
                    else if (m_long && R != 0 && m_hold > L && ((m_hold - L) % R) == 0) e_rep = 1;
                end
                default: if (lvl) begin
                    e_press = 1; m_presses = 2; m_hold = 0; m_phase = 1;
                end else begin
                    m_low++;
                    if (m_low == G) begin e_click = 1; m_phase = 0; end
                end
            endcase
        end
        exp_vec = {(rst_n && m_phase == 1), e_press, e_rel, e_click, e_dbl, e_long, e_rep};
    endtask

    task automatic clear_stats();
        n_press = 0; n_rel = 0; n_click = 0; n_dbl = 0; n_long = 0; n_rep = 0;
        t_press = -1; t_rel = -1; t_click = -1; t_dbl = -1; t_long = -1; t_rep1 = -1;
    endtask

    task automatic step(input logic lvl, input logic rst_n);
        bif.in = lvl;
        resetn = rst_n;
        @(posedge clk);
        model_edge(lvl, rst_n);
        #1;
        cyc++;
        check_eq("outs", {bif.held, bif.press, bif.release_pulse, bif.click,
                          bif.double_click, bif.long_press, bif.repeat_pulse}, {25'd0, exp_vec});
        if (bif.press)         begin n_press++; t_press = cyc; end
        if (bif.release_pulse) begin n_rel++;   t_rel   = cyc; end
        if (bif.click)         begin n_click++; t_click = cyc; end
        if (bif.double_click)  begin n_dbl++;   t_dbl   = cyc; end
        if (bif.long_press)    begin n_long++;  t_long  = cyc; end
        if (bif.repeat_pulse)  begin if (n_rep == 0) t_rep1 = cyc; n_rep++; end
    endtask

    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl, 1'b1);
    endtask

    task automatic hold_reset(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl, 1'b0);
    endtask

    initial begin
        bif.in = 1'b0;
        clear_stats();

        // Reset with the button held, then the first sampled high edge presses.
        hold_reset(1'b1, 3);
        check_eq("rst_held", {31'd0, bif.held}, 32'd0);
        check_eq("rst_press", {31'd0, bif.press}, 32'd0);
        step(1'b1, 1'b1);
        check_eq("first_press", {31'd0, bif.press}, 32'd1);
        check_eq("first_held", {31'd0, bif.held}, 32'd1);
        drive(1'b0, G + 4);

        // Single click.
        clear_stats();
        drive(1'b1, 5); drive(1'b0, G + 4);
        check_eq("clk_rel_lat", t_rel - t_press, 32'd5);
        check_eq("clk_click_lat", t_click - t_rel, G);
        check_eq("clk_long", n_long, 32'd0);
        check_eq("clk_dbl", n_dbl, 32'd0);

        // Double click.
        clear_stats();
        drive(1'b1, 4); drive(1'b0, 3); drive(1'b1, 4); drive(1'b0, G + 4);
        check_eq("dbl_press", n_press, 32'd2);
        check_eq("dbl_cnt", n_dbl, 32'd1);
        check_eq("dbl_with_rel", t_dbl, t_rel);
        check_eq("dbl_click", n_click, 32'd0);

        // Second rise exactly at R0+G is still a double-click.
        clear_stats();
        drive(1'b1, 4); drive(1'b0, G); drive(1'b1, 3); drive(1'b0, G + 4);
        check_eq("gapb_dbl", n_dbl, 32'd1);
        check_eq("gapb_click", n_click, 32'd0);

        // Long press with repeat.
        clear_stats();
        drive(1'b1, 40); drive(1'b0, G + 4);
        check_eq("long_lat", t_long - t_press, L);
        check_eq("rep_first", t_rep1 - t_long, R);
        check_eq("rep_cnt", n_rep, 32'd3);
        check_eq("long_click", n_click, 32'd0);
        check_eq("long_rel", n_rel, 32'd1);

        // Low sampled exactly at E0+L is a short press.
        clear_stats();
        drive(1'b1, L); drive(1'b0, G + 4);
        check_eq("longb_long", n_long, 32'd0);
        check_eq("longb_click", t_click - t_rel, G);

        // Reset during the gap and during the long hold.
        clear_stats();
        drive(1'b1, 3); drive(1'b0, 3); hold_reset(1'b0, 2); drive(1'b0, G + 4);
        check_eq("rstgap_click", n_click, 32'd0);
        clear_stats();
        drive(1'b1, L + 2); hold_reset(1'b0, 2); drive(1'b0, 12);
        check_eq("rstlong_rep", n_rep, 32'd0);
        check_eq("rstlong_held", {31'd0, bif.held}, 32'd0);
        clear_stats();
        drive(1'b1, 3); drive(1'b0, G + 4);
        check_eq("rst_after_click", n_click, 32'd1);

        // Random gestures, with occasional resets, against the model.
        for (int i = 0; i < 400; i++) begin
            int len;
            len = (($urandom % 4) == 0) ? int'($urandom_range(15, 35)) : int'($urandom_range(1, 12));
            if (($urandom % 40) == 0) hold_reset(1'($urandom % 2), $urandom_range(1, 3));
            else drive(1'(i % 2 == 0), len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
